comp4_minmax_seq: RTL
=====================

// Module: comp4_minmax_seq
// PURPOSE
//  Sequencer that drives the shared 4-bit magnitude comparator (l/g/e outputs) over a
//  burst of input samples and reports the burst's max and min, their indices and the count.
//  One comparator instance is time-multiplexed: each sample after the first takes one
//  compare cycle against the running max and one against the running min.
//  Sits between a valid/ready sample source and a valid/ready result consumer.
// PARAMETERS
//  W       4   sample width; cmp_a/cmp_b width
//  MAXLEN  16  max samples per burst; CW=$clog2(MAXLEN+1), IW=$clog2(MAXLEN)
// PORTS
//  clk          in   1   single clock; all state changes on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  in_valid     in   1   sample present
//  in_ready     out  1   sample accepted when in_valid&&in_ready
//  in_data      in   W   sample value (unsigned)
//  in_last      in   1   final sample of burst, qualified by in_valid
//  cmp_a        out  W   comparator operand A (latched sample)
//  cmp_b        out  W   comparator operand B (running max or min)
//  cmp_l        in   1   comparator A<B (combinational, same cycle)
//  cmp_g        in   1   comparator A>B
//  cmp_e        in   1   comparator A==B
//  out_valid    out  1   result valid, held until out_ready
//  out_ready    in   1   consumer accepts result
//  out_max      out  W   burst maximum
//  out_min      out  W   burst minimum
//  out_max_idx  out  IW  index (0-based) of first occurrence of max
//  out_min_idx  out  IW  index of first occurrence of min
//  out_count    out  CW  samples in burst (1..MAXLEN)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=S_IN; in_ready=1; out_valid=0; out_max/out_min/indices/
//   out_count=0; cmp_a=cmp_b=0; internal sample, last flag, count cleared. Reset mid-burst
//   discards partial burst; no result issued.
//  States: S_IN, S_MAX, S_MIN, S_OUT. in_ready=1 only in S_IN; out_valid=1 only in S_OUT.
//  S_IN, accept, count==0: load max=min=in_data, both idx=0, count=1; no compare.
//   -> S_OUT if last_eff else stay S_IN.
//  S_IN, accept, count>0: latch sample, idx=count, last_eff; count++ -> S_MAX.
//  S_MAX: cmp_a=sample, cmp_b=max; if cmp_g: max=sample, max_idx=idx. -> S_MIN.
//  S_MIN: cmp_a=sample, cmp_b=min; if cmp_l: min=sample, min_idx=idx.
//   -> S_OUT if latched last_eff else S_IN.
//  last_eff = in_last || (count+1 == MAXLEN); MAXLEN-th sample force-terminates burst.
//  Ties (cmp_e): no update; earliest index retained. cmp_e otherwise unused.
//  Latency: non-first sample occupies 3 cycles (accept, S_MAX, S_MIN); 1-sample burst
//   gives out_valid the cycle after accept; N-sample burst gives out_valid 3 cycles after
//   the last accept (or 1 cycle if N=1).
//  S_OUT: outputs registered and stable while out_valid=1 && !out_ready. On out_ready:
//   out_valid=0, count cleared -> S_IN; next burst accepted from the following cycle.
//   Result outputs keep last values after handshake (don't-care for consumer).
//  cmp_a/cmp_b are registered-stable in S_MAX/S_MIN; hold prior values in other states.
//  in_last with in_valid=0 is ignored. Comparator outputs sampled only in S_MAX/S_MIN.
// TESTING
//  Burst 1,5,3,5,0(last) -> max=5 idx=1, min=0 idx=4, count=5 (tie on 2nd 5 no update)
//  Single sample 7(last) -> out_valid 1 cycle after accept; max=min=7, idx 0/0, count=1
//  16 samples 0..15 with in_last=0 throughout -> forced end: max=15 idx=15, min=0 idx=0, count=16
//  All-equal burst 4,4,4(last) -> max=min=4, both idx=0, count=3
//  out_ready held 0 for 5 cycles -> outputs stable, in_ready=0; then 1 -> S_IN, new burst 2,9 ok
//  rst_n low during S_MAX of burst 3,8 -> all outputs 0, in_ready=1; next burst 6(last) -> max=min=6

Source files
------------

// File: rtl/comp4_minmax_seq.sv
// Burst min/max sequencer: time-multiplexes one external magnitude comparator to track
// the running max/min of a valid/ready sample burst and emits max, min, indices and count.
module comp4_minmax_seq #(
    parameter  int unsigned W      = 4,
    parameter  int unsigned MAXLEN = 16,
    localparam int unsigned CW     = $clog2(MAXLEN + 1),
    localparam int unsigned IW     = $clog2(MAXLEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic [W-1:0]  cmp_a,
    output logic [W-1:0]  cmp_b,
    input  logic          cmp_l,
    input  logic          cmp_g,
    input  logic          cmp_e,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_max,
    output logic [W-1:0]  out_min,
    output logic [IW-1:0] out_max_idx,
    output logic [IW-1:0] out_min_idx,
    output logic [CW-1:0] out_count
);

    typedef enum logic [1:0] {S_IN, S_MAX, S_MIN, S_OUT} state_t;

    state_t        state_q;
    logic [W-1:0]  sample_q, max_q, min_q, cmp_a_q, cmp_b_q;
    logic [IW-1:0] idx_q, max_idx_q, min_idx_q;
    logic [CW-1:0] count_q;
    logic          last_q, in_ready_q, out_valid_q;
    logic [W-1:0]  out_max_q, out_min_q;
    logic [IW-1:0] out_max_idx_q, out_min_idx_q;
    logic [CW-1:0] out_count_q;

    logic [CW-1:0] count_inc_d;
    logic          last_eff_d, max_upd_d, min_upd_d;
    logic [W-1:0]  min_d;
    logic [IW-1:0] min_idx_d;

    // A tie asserts cmp_e; gating with it keeps the earliest index even on a noisy comparator.
    always_comb begin
        count_inc_d = count_q + CW'(1);
        last_eff_d  = in_last || (count_inc_d == CW'(MAXLEN));
        max_upd_d   = cmp_g && !cmp_e;
        min_upd_d   = cmp_l && !cmp_e;
        min_d       = min_upd_d ? sample_q : min_q;
        min_idx_d   = min_upd_d ? idx_q    : min_idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IN;
            sample_q      <= '0;
            max_q         <= '0;
            min_q         <= '0;
            cmp_a_q       <= '0;
            cmp_b_q       <= '0;
            idx_q         <= '0;
            max_idx_q     <= '0;
            min_idx_q     <= '0;
            count_q       <= '0;
            last_q        <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_max_q     <= '0;
            out_min_q     <= '0;
            out_max_idx_q <= '0;
            out_min_idx_q <= '0;
            out_count_q   <= '0;
        end else begin
            case (state_q)
                S_IN: begin
                    if (in_valid) begin
                        if (count_q == '0) begin
                            max_q     <= in_data;
                            min_q     <= in_data;
                            max_idx_q <= '0;
                            min_idx_q <= '0;
                            count_q   <= CW'(1);
                            if (last_eff_d) begin
                                state_q       <= S_OUT;
                                in_ready_q    <= 1'b0;
                                out_valid_q   <= 1'b1;
                                out_max_q     <= in_data;
                                out_min_q     <= in_data;
                                out_max_idx_q <= '0;
                                out_min_idx_q <= '0;
                                out_count_q   <= CW'(1);
                            end
                        end else begin
                            sample_q   <= in_data;
                            idx_q      <= count_q[IW-1:0];
                            last_q     <= last_eff_d;
                            count_q    <= count_inc_d;
                            cmp_a_q    <= in_data;
                            cmp_b_q    <= max_q;
                            state_q    <= S_MAX;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                S_MAX: begin
                    if (max_upd_d) begin
                        max_q     <= sample_q;
                        max_idx_q <= idx_q;
                    end
                    cmp_b_q <= min_q;
                    state_q <= S_MIN;
                end
                S_MIN: begin
                    min_q     <= min_d;
                    min_idx_q <= min_idx_d;
                    if (last_q) begin
                        state_q       <= S_OUT;
                        out_valid_q   <= 1'b1;
                        out_max_q     <= max_q;
                        out_max_idx_q <= max_idx_q;
                        out_min_q     <= min_d;
                        out_min_idx_q <= min_idx_d;
                        out_count_q   <= count_q;
                    end else begin
                        state_q    <= S_IN;
                        in_ready_q <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state_q     <= S_IN;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        count_q     <= '0;
                    end
                end
                default: begin
                    state_q     <= S_IN;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    count_q     <= '0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign cmp_a       = cmp_a_q;
    assign cmp_b       = cmp_b_q;
    assign out_max     = out_max_q;
    assign out_min     = out_min_q;
    assign out_max_idx = out_max_idx_q;
    assign out_min_idx = out_min_idx_q;
    assign out_count   = out_count_q;

endmodule
